regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port integer register file with asynchronous reset, in-cycle write-to-read bypass and a per-register pending-write scoreboard. It replaces the single-write, two-read register file in the pipelined RV32 core: decode reads operands and checks hazards through it, and the writeback stage(s) commit results into it. Register 0 reads as zero, is never written and is never busy.

## Interface
- ADDRESS_WIDTH, 5: register index width; depth is 2**ADDRESS_WIDTH.
- DATA_WIDTH, 32: register width.
- NUM_READ, 2: number of combinational read ports.
- NUM_WRITE, 2: number of write ports.
- DEBUG_REG, 10: index driven onto `a0`.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_READ*ADDRESS_WIDTH  packed read addresses; port i is slice i.
- rd_data  out  NUM_READ*DATA_WIDTH  packed read data.
- rd_ready  out  NUM_READ  operand i is valid, i.e. not awaiting a write.
- issue_valid  in  1  mark `issue_addr` as pending a write.
- issue_addr  in  ADDRESS_WIDTH  destination of the issued instruction.
- we  in  NUM_WRITE  per-port write enable.
- wr_addr  in  NUM_WRITE*ADDRESS_WIDTH  packed write addresses.
- wr_data  in  NUM_WRITE*DATA_WIDTH  packed write data.
- busy  out  2**ADDRESS_WIDTH  scoreboard vector; bit 0 is constant 0.
- a0  out  DATA_WIDTH  stored value of register DEBUG_REG, with no bypass.

## Operation
- **Reset (rst=1):**
  - All registers clear to 0 and all busy bits clear to 0, asynchronously.
  - Outputs during reset: rd_data is 0, rd_ready is all-ones, busy is 0, a0 is 0.
- **Writes:**
  - Port j commits wr_data[j] to wr_addr[j] at the clock edge when we[j]=1 and wr_addr[j]≠0.
  - Writes to address 0 are discarded.
  - If several ports write the same address, the highest-index port wins.
- **Reads:**
  - rd_data[i] is 0 when rd_addr[i]=0.
  - Otherwise rd_data[i] is the bypassed value when bypass applies (see Configuration), else the stored value.
- **Scoreboard:**
  - An enabled write to address a (≠0) clears busy[a] at the edge.
  - issue_valid=1 with issue_addr≠0 sets busy[issue_addr] at the edge.
  - Issue and write to the same address in the same cycle: set wins and busy stays 1, because a new producer supersedes the old one.
  - A write to a non-busy register is legal and leaves busy at 0.
  - issue_addr=0 is ignored.
- **rd_ready[i]:**
  - 1 if rd_addr[i]=0.
  - Otherwise 1 if busy[rd_addr[i]]=0, or if bypass is enabled and an enabled write port targets rd_addr[i] this cycle.
  - Otherwise 0.

## Timing
- Reads, rd_ready and a0 are combinational from the current state plus, with bypass, the current write ports. Read latency is 0 cycles.
- A write is visible in storage, in a0 and to non-bypassed reads from the cycle after the edge.
- Busy set and clear take effect after the edge.
- Asserting rst mid-operation takes effect immediately, without waiting for clk. The first edge after rst deasserts performs normal updates.
- No internal handshake: the caller stalls decode while any required rd_ready is 0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read address matching an enabled, nonzero write address returns that port's wr_data in the same cycle, with the highest-index matching port winning.
  - rd_ready is asserted for the matched operand.
- Undefined:
  - Reads return only stored values and rd_ready depends only on busy.
  - A value written at edge N is readable from cycle N+1.

## Structure
- Package `regfile_pkg`:
  - ADDRESS_WIDTH/DATA_WIDTH defaults.
  - `reg_idx_t` and `reg_word_t` typedefs.
  - ZERO_REG constant.
  - DEBUG_REG default (10).
- Sub-module `regfile_scoreboard` owns the busy vector and its set/clear priority. The storage array and read/bypass muxing stay in the top module.

## Test plan
- **Reset:** write 0xDEADBEEF to x5, then assert rst asynchronously between edges → x5 reads 0, busy is 0, a0 is 0 before the next edge.
- **Dual write, no conflict:** port0 writes x10=0x11, port1 writes x11=0x22 in one cycle → next cycle a0=0x11, a read of x11 returns 0x22.
- **Write conflict:** port0 and port1 both write x7 (0xAAAA / 0x5555) → x7=0x5555.
- **x0:** write 0x1234 to x0 and issue x0 → reads of x0 return 0, busy[0]=0, rd_ready=1.
- **Scoreboard:**
  - Issue x3 → rd_ready=0 on x3 next cycle.
  - Issue x3 and write x3 in the same cycle → busy[3] stays 1.
  - A later write of x3 clears it.
- **Bypass:** write x4=0xCAFE while reading x4 with busy[4]=1.
  - With REGFILE_BYPASS_EN: rd_data=0xCAFE and rd_ready=1 in the same cycle.
  - Without it: old value and rd_ready=0, then 0xCAFE with rd_ready=1 next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared defaults and types for the multi-port register file.
//   DEFAULT_ADDRESS_WIDTH : register index width (depth = 2**width)
//   DEFAULT_DATA_WIDTH    : register width
//   DEFAULT_DEBUG_REG     : register mirrored onto the a0 debug output
//   reg_idx_t / reg_word_t: index and word types at the default widths
//   ZERO_REG              : hardwired-zero register index
package regfile_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 5;
    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_DEBUG_REG     = 10;

    typedef logic [DEFAULT_ADDRESS_WIDTH-1:0] reg_idx_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0]    reg_word_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Per-register pending-write tracking. A register is busy from the edge its
// producer issues until the edge a write port commits to it.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   issue_valid  : set busy[issue_addr] at the edge (ignored for x0)
//   issue_addr   : destination of the issued instruction
//   we, wr_addr  : packed write-port enables/addresses; clear busy at the edge
//   busy         : scoreboard vector, bit 0 always 0
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int NUM_WRITE     = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               issue_valid,
    input  logic [ADDRESS_WIDTH-1:0]           issue_addr,
    input  logic [NUM_WRITE-1:0]               we,
    input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wr_addr,
    output logic [2**ADDRESS_WIDTH-1:0]        busy
);

    localparam int DEPTH = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(ZERO_REG);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_next;

    // Clears are applied first so that a same-cycle issue overrides them:
    // the newly issued producer supersedes the one that is completing.
    always_comb begin
        busy_next = busy_q;
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (we[j] && wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] != ZERO_IDX)
                busy_next[wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = 1'b0;
        end
        if (issue_valid && issue_addr != ZERO_IDX)
            busy_next[issue_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_next;
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port integer register file with a pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to reads.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   rd_addr      : packed read addresses, port i in slice i
//   rd_data      : packed combinational read data (x0 reads 0)
//   rd_ready     : per read port, operand not awaiting a write
//   issue_valid  : mark issue_addr as pending a write
//   issue_addr   : destination of the issued instruction
//   we           : per write-port enable
//   wr_addr      : packed write addresses
//   wr_data      : packed write data
//   busy         : scoreboard vector, bit 0 always 0
//   a0           : stored (non-bypassed) value of register DEBUG_REG
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int NUM_READ      = 2,
    parameter int NUM_WRITE     = 2,
    parameter int DEBUG_REG     = DEFAULT_DEBUG_REG
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]     rd_data,
    output logic [NUM_READ-1:0]                rd_ready,
    input  logic                               issue_valid,
    input  logic [ADDRESS_WIDTH-1:0]           issue_addr,
    input  logic [NUM_WRITE-1:0]               we,
    input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]    wr_data,
    output logic [2**ADDRESS_WIDTH-1:0]        busy,
    output logic [DATA_WIDTH-1:0]              a0
);

    localparam int DEPTH = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(ZERO_REG);
    localparam logic [ADDRESS_WIDTH-1:0] DBG_IDX  = ADDRESS_WIDTH'(DEBUG_REG);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    regfile_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .NUM_WRITE     (NUM_WRITE)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .we          (we),
        .wr_addr     (wr_addr),
        .busy        (busy)
    );

    // Later loop iterations overwrite earlier ones, so the highest-index
    // port wins on an address collision. mem[0] is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= '0;
        end else begin
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (we[j] && wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] != ZERO_IDX)
                    mem[wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH]]
                        <= wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    genvar i;
    for (i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0]    rdat;
        logic                     rrdy;

        assign ra = rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];

        always_comb begin
            rdat = '0;
            rrdy = 1'b1;
            if (ra != ZERO_IDX) begin
                rdat = mem[ra];
                rrdy = ~busy[ra];
`ifdef REGFILE_BYPASS_EN
                // Suppressed in reset so the outputs read as cleared state.
                if (!rst) begin
                    for (int j = 0; j < NUM_WRITE; j++) begin
                        if (we[j] && wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] == ra) begin
                            rdat = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                            rrdy = 1'b1;
                        end
                    end
                end
`endif
            end
        end

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rdat;
        assign rd_ready[i] = rrdy;
    end

    assign a0 = mem[DBG_IDX];

endmodule
